// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one BLOCK-bit lookahead slice per stage, valid/ready on both sides.
// Optional saturation of out_sum enabled by defining CLA_SAT_EN (flags always reflect the raw result).
module cla_pipe_adder #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned BLOCK      = 8,
    parameter int unsigned LOCAL_BITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_local_ovf
);
    localparam int unsigned STAGES = WIDTH / BLOCK;
    localparam int unsigned NG     = BLOCK / 4;

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Two-level lookahead: 4-bit group carries, then group generate/propagate across the block.
    function automatic logic [BLOCK:0] cla_block(input logic [BLOCK-1:0] a,
                                                 input logic [BLOCK-1:0] b,
                                                 input logic             cin);
        logic [BLOCK-1:0] g, p, c;
        logic [NG-1:0]    gg, gp;
        logic [NG:0]      gc;
        g = a & b;
        p = a | b;
        for (int unsigned j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        gc[0] = cin;
        for (int unsigned j = 0; j < NG; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int unsigned j = 0; j < NG; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        return {gc[NG], a ^ b ^ c};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned HI = WIDTH - k * BLOCK;

        logic [HI-1:0]          a_i, b_i;
        logic                   c_i, sub_i, v_i;
        logic [BLOCK-1:0]       b_blk;
        logic [BLOCK:0]         r;
        logic [(k+1)*BLOCK-1:0] s_o;

        // Each stage only carries the operand bits still to be resolved and the sum bits already resolved.
        if (k == 0) begin : g_first
            assign a_i   = in_a;
            assign b_i   = in_b;
            assign c_i   = in_sub;
            assign sub_i = in_sub;
            assign v_i   = in_valid;
            assign s_o   = r[BLOCK-1:0];
        end else begin : g_next
            assign a_i   = g_stage[k-1].g_reg.a_q;
            assign b_i   = g_stage[k-1].g_reg.b_q;
            assign c_i   = g_stage[k-1].g_reg.c_q;
            assign sub_i = g_stage[k-1].g_reg.sub_q;
            assign v_i   = g_stage[k-1].g_reg.v_q;
            assign s_o   = {r[BLOCK-1:0], g_stage[k-1].g_reg.s_q};
        end

        assign b_blk = b_i[BLOCK-1:0] ^ {BLOCK{sub_i}};
        assign r     = cla_block(a_i[BLOCK-1:0], b_blk, c_i);

        if (k < STAGES - 1) begin : g_reg
            logic [HI-BLOCK-1:0]    a_q, b_q;
            logic [(k+1)*BLOCK-1:0] s_q;
            logic                   c_q, sub_q, v_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q   <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    s_q   <= '0;
                    c_q   <= 1'b0;
                    sub_q <= 1'b0;
                end else if (en) begin
                    v_q   <= v_i;
                    a_q   <= a_i[HI-1:BLOCK];
                    b_q   <= b_i[HI-1:BLOCK];
                    s_q   <= s_o;
                    c_q   <= r[BLOCK];
                    sub_q <= sub_i;
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] sum_d;
            logic             ovf_d;

            assign ovf_d = (a_i[BLOCK-1] == b_blk[BLOCK-1]) && (s_o[WIDTH-1] != a_i[BLOCK-1]);

`ifdef CLA_SAT_EN
            always_comb begin
                sum_d = s_o;
                if (!sub_i && r[BLOCK]) begin
                    sum_d = '1;
                end else if (sub_i && !r[BLOCK]) begin
                    sum_d = '0;
                end
            end
`else
            assign sum_d = s_o;
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid     <= 1'b0;
                    out_sum       <= '0;
                    out_cout      <= 1'b0;
                    out_ovf       <= 1'b0;
                    out_local_ovf <= 1'b0;
                end else if (en) begin
                    out_valid     <= v_i;
                    out_sum       <= sum_d;
                    out_cout      <= r[BLOCK];
                    out_ovf       <= ovf_d;
                    out_local_ovf <= |s_o[WIDTH-1:LOCAL_BITS];
                end
            end
        end
    end

endmodule
